conv_window_engine: RTL
=======================

Name: conv_window_engine

Overview:
Streaming KxK sliding-window convolution engine: successor to the fixed 3-row, two-window loader. Accepts one K-pixel column per handshake from the line buffers. Holds a full KxK window in a shift register and applies a programmable signed kernel. Emits one accumulated result per valid window position at a runtime stride (1..3). Sits between the line-buffer block and the activation/pooling stage of the NPU datapath.

Parameters:
BIT_DEPTH, 8, pixel and weight width
KERNEL, 3, window height/width K (2..5)
IMG_WIDTH, 32, columns per row (>= KERNEL)
ACC_W, 2*BIT_DEPTH+$clog2(KERNEL*KERNEL)+1, result width (signed)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin one row pass; sampled in IDLE only
stride  in  2  column stride; 0 treated as 1
wt_we  in  1  weight write strobe, honoured in IDLE only
wt_addr  in  $clog2(KERNEL*KERNEL)  weight index, row-major (r*K+c)
wt_data  in  BIT_DEPTH  signed weight
in_valid  in  1  column available
in_ready  out  1  engine accepts column
in_col  in  KERNEL*BIT_DEPTH  unsigned pixels, row 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  signed convolution result
shift_buffer  out  1  pulses with every accepted column (line-buffer advance)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of row pass

Behaviour:
- Reset (async): state IDLE, weights 0, window 0, counters 0, in_ready/out_valid/shift_buffer/busy/done 0, out_data 0.
- Column accept = in_valid && in_ready. in_ready = (state FILL or STREAM) && (!out_valid || out_ready).
- Accept: window shifts one column (oldest column dropped), col_cnt increments, shift_buffer=1 that cycle (combinational on accept).
- FSM:
  - IDLE: on start, latch stride_q (max(stride,1)), clear col_cnt and phase, go to FILL. Weight writes are allowed only in IDLE.
  - FILL: accept until col_cnt==KERNEL, then go to STREAM.
  - STREAM: keep accepting until col_cnt==IMG_WIDTH, then go to DRAIN.
  - DRAIN: wait until !out_valid || out_ready, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Window emission:
  - An accept that makes col_cnt >= KERNEL evaluates the window including the new column.
  - Emit when phase==0, where phase counts 0..stride_q-1 and resets to 0 on wrap.
  - phase starts at 0 on the accept making col_cnt==KERNEL and advances on each later accept.
  - Outputs per row = floor((IMG_WIDTH-KERNEL)/stride_q)+1.
- Latency: the result is registered. out_valid rises the cycle after the emitting accept.
- Output handshake:
  - out_valid holds, and out_data is stable, until out_ready.
  - A new emission in the same cycle as a handshake overwrites the register and keeps out_valid high.
- Arithmetic: the result is the sum over r,c of $signed({1'b0,pixel}) * weight, computed at full ACC_W width. No overflow is possible.
- Edge cases:
  - start while busy: ignored.
  - wt_we outside IDLE: ignored.
  - stride changes mid-pass: no effect.
  - in_valid in IDLE/DRAIN/DONE: no accept.
  - rst mid-pass: immediate return to IDLE; weights are cleared too.
  - KERNEL==IMG_WIDTH: exactly one output.

Optional Feature:
CONV_RELU_EN defined: out_data = (sum<0) ? 0 : sum, applied before the output register.
Undefined: raw signed sum. The port width is the same in both builds.

Decomposition:
- Package conv_pkg holds:
  - the state enum (IDLE, FILL, STREAM, DRAIN, DONE);
  - the acc_width(bit_depth,kernel) function;
  - the stride normalisation constant MIN_STRIDE=1.
- One sub-module, conv_mac_tree: purely combinational KxK multiply and adder tree (window, weights -> sum). The FSM, window register and output register stay in conv_window_engine.

Test Plan:
- K=3, W=8, stride=1, all weights 1, all pixels 10 -> 6 results of 90; shift_buffer pulses 8 times; done pulses once.
- Identity kernel (w[4]=1, others 0), column j pixels = j+1, stride=2 -> results 2,4,6 (centre column); exactly 3 outputs.
- stride=0 input -> behaves as stride 1: 6 outputs.
- out_ready held low 5 cycles after the first result -> in_ready low throughout, out_data stable, no results lost, 6 total.
- Weights all -1, pixels 255 -> -2295 without CONV_RELU_EN; 0 with it.
- rst asserted mid-STREAM after 4 accepts -> same-cycle in_ready/out_valid/busy=0; a subsequent wt readback via an all-ones-pixel pass yields 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK sliding-window convolution engine.
package conv_pkg;

    // Row-pass control states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // A stride request of zero is promoted to this value.
    localparam logic [1:0] MIN_STRIDE = 2'd1;

    // Signed result width large enough that a full KxK sum of
    // (unsigned pixel * signed weight) products can never overflow.
    function automatic int acc_width(input int bit_depth, input int kernel);
        return 2 * bit_depth + $clog2(kernel * kernel) + 1;
    endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Purely combinational KxK multiply-accumulate: window pixels (unsigned)
// times kernel weights (signed), summed at full result width.
module conv_mac_tree
    import conv_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int KERNEL    = 3,
    parameter int ACC_W     = acc_width(BIT_DEPTH, KERNEL)
) (
    input  logic [KERNEL-1:0][KERNEL-1:0][BIT_DEPTH-1:0] window_i,
    input  logic [KERNEL-1:0][KERNEL-1:0][BIT_DEPTH-1:0] weights_i,
    output logic signed [ACC_W-1:0]                      sum_o
);

    // Sum all KxK products; each operand is extended to ACC_W before the multiply.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sum_o = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                sum_o = sum_o
                      + (ACC_W'($signed({1'b0, window_i[r][c]}))
                      *  ACC_W'($signed(weights_i[r][c])));
            end
        end
    end

endmodule

// File: rtl/conv_window_engine.sv
// Streaming KxK sliding-window convolution engine. Accepts one K-pixel
// column per handshake, keeps the KxK window in a shift register, and emits
// one registered signed result per window position at a runtime stride.
// Optional build macro CONV_RELU_EN clamps negative results to zero before
// the output register; the port width is identical in both builds.
module conv_window_engine
    import conv_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int KERNEL    = 3,
    parameter int IMG_WIDTH = 32,
    parameter int ACC_W     = acc_width(BIT_DEPTH, KERNEL)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [1:0]                          stride,
    input  logic                                wt_we,
    input  logic [$clog2(KERNEL*KERNEL)-1:0]    wt_addr,
    input  logic [BIT_DEPTH-1:0]                wt_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [KERNEL*BIT_DEPTH-1:0]         in_col,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [ACC_W-1:0]             out_data,
    output logic                                shift_buffer,
    output logic                                busy,
    output logic                                done
);

    localparam int ADDR_W = $clog2(KERNEL * KERNEL);
    localparam int CNT_W  = $clog2(IMG_WIDTH + 1);

    typedef logic [KERNEL-1:0][KERNEL-1:0][BIT_DEPTH-1:0] grid_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        col_cnt_q, col_cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic [1:0]              stride_q, stride_d;
    grid_t                   window_q, window_d;
    grid_t                   weights_q, weights_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;

    logic                    accept;
    logic                    emit;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] result;

    // The sum sees the window including the column being accepted this cycle.
    conv_mac_tree #(
        .BIT_DEPTH (BIT_DEPTH),
        .KERNEL    (KERNEL),
        .ACC_W     (ACC_W)
    ) u_mac_tree (
        .window_i  (window_d),
        .weights_i (weights_q),
        .sum_o     (sum)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // FSM next state: row pass is fill, stream, drain the last result, pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (accept && col_cnt_d == CNT_W'(KERNEL))
                         state_d = (KERNEL == IMG_WIDTH) ? DRAIN : STREAM;
            STREAM:  if (accept && col_cnt_d == CNT_W'(IMG_WIDTH)) state_d = DRAIN;
            DRAIN:   if (!out_valid_q || out_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: columns are taken only while the result slot is free or draining.
    always_comb begin
        in_ready = ((state_q == FILL) || (state_q == STREAM)) && (!out_valid_q || out_ready);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    assign accept       = in_valid && in_ready;
    assign shift_buffer = accept;

    // Datapath next state: pass setup, weight writes, window shift and stride phase.
    always_comb begin
        col_cnt_d = col_cnt_q;
        phase_d   = phase_q;
        stride_d  = stride_q;
        window_d  = window_q;
        weights_d = weights_q;
        emit      = 1'b0;

        if (state_q == IDLE) begin
            if (start) begin
                stride_d  = (stride == 2'd0) ? MIN_STRIDE : stride;
                col_cnt_d = '0;
                phase_d   = '0;
            end
            if (wt_we) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int c = 0; c < KERNEL; c++) begin
                        if (wt_addr == ADDR_W'(r * KERNEL + c)) weights_d[r][c] = wt_data;
                    end
                end
            end
        end

        if (accept) begin
            col_cnt_d = col_cnt_q + 1'b1;
            // Column 0 is the oldest; the new column enters at KERNEL-1.
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    window_d[r][c] = window_q[r][c+1];
                end
                window_d[r][KERNEL-1] = in_col[r*BIT_DEPTH +: BIT_DEPTH];
            end
            // Phase is still 0 on the accept that first completes a window.
            if (col_cnt_d >= CNT_W'(KERNEL)) begin
                emit    = (phase_q == 2'd0);
                phase_d = (phase_q + 2'd1 == stride_q) ? 2'd0 : phase_q + 2'd1;
            end
        end
    end

    // Optional ReLU ahead of the output register.
    always_comb begin
`ifdef CONV_RELU_EN
        result = sum[ACC_W-1] ? '0 : sum;
`else
        result = sum;
`endif
    end

    // Output slot: load on emit, otherwise clear on handshake; data holds while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q   <= '0;
            phase_q     <= '0;
            stride_q    <= '0;
            window_q    <= '0;
            // NOTE: the weight store is flops, not RAM, so it can and must be cleared by reset.
            weights_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            phase_q     <= phase_d;
            stride_q    <= stride_d;
            window_q    <= window_d;
            weights_q   <= weights_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
